// File: rtl/trace_pkg.sv
// Shared definitions for the activity trace recorder.
//   - Default parameter values for the recorder.
//   - entry_w(): width of one packed trace entry {ch_id, timestamp, addr, data}.
//   - trace_entry_t: packed entry layout at the default widths. Use it when
//     building or decoding entries outside the parameterised top.
package trace_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 6;
    localparam int TS_W_DEF   = 16;
    localparam int DEPTH_DEF  = 16;
    localparam int DROP_W     = 16;

    // ch_id occupies the MSBs, followed by timestamp, address and data.
    function automatic int entry_w(input int num_ch, input int ts_w,
                                   input int addr_w, input int data_w);
        return $clog2(num_ch) + ts_w + addr_w + data_w;
    endfunction

    typedef struct packed {
        logic [$clog2(NUM_CH_DEF)-1:0] ch_id;
        logic [TS_W_DEF-1:0]           ts;
        logic [ADDR_W_DEF-1:0]         addr;
        logic [DATA_W_DEF-1:0]         data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO for trace entries.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   i_clear          synchronous flush; it takes priority over push and pop
//   i_push, i_data   write request and its entry; ignored when full unless
//                    a pop happens in the same cycle
//   i_pop            read request; ignored when empty
//   o_valid, o_data  head entry, valid whenever the FIFO is not empty
//   o_full           all DEPTH entries are in use
//   o_count          number of entries held
// DEPTH must be a power of two so the pointers can wrap naturally.
module trace_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 40,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // When full, a simultaneous pop frees the slot being written. The head
    // is read combinationally before the edge, so the overwrite is safe.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The storage array has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule

// File: rtl/activity_trace_recorder.sv
// Activity trace recorder: captures per-channel events (register-file ports,
// sequencer PCs, SRAM write ports) with an execution-cycle timestamp. Each
// event is first held in a one-entry slot per channel. A round-robin arbiter
// then moves it into a show-ahead FIFO.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   enable           capture enable; it also gates the cycle counter
//   clear            synchronous flush of all trace state
//   ch_mask          per-channel capture enable
//   change_only      per-channel: log only when the data differs from the
//                    last logged value
//   ev_valid/addr/data  per-channel event strobes and packed payloads,
//                    with channel 0 in the LSBs
//   out_valid/ready/entry  valid/ready stream of {ch_id, ts, addr, data}
//   fifo_count       number of entries in the FIFO
//   drop_count       events lost because their slot was busy; saturates
//   cycle_count      execution cycle counter, which also supplies the timestamp
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high. out_entry holds steady while out_valid is high
// and out_ready is low.
module activity_trace_recorder
    import trace_pkg::*;
#(
    parameter  int NUM_CH  = NUM_CH_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int TS_W    = TS_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int CH_W    = $clog2(NUM_CH),
    localparam int ENTRY_W = entry_w(NUM_CH, TS_W, ADDR_W, DATA_W),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH-1:0]        change_only,
    input  logic [NUM_CH-1:0]        ev_valid,
    input  logic [NUM_CH*ADDR_W-1:0] ev_addr,
    input  logic [NUM_CH*DATA_W-1:0] ev_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENTRY_W-1:0]       out_entry,
    output logic [CNT_W-1:0]         fifo_count,
    output logic [DROP_W-1:0]        drop_count,
    output logic [TS_W-1:0]          cycle_count
);

    // Pending slots and last-logged values
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_has_last;
    logic [TS_W-1:0]   r_slot_ts   [NUM_CH];
    logic [ADDR_W-1:0] r_slot_addr [NUM_CH];
    logic [DATA_W-1:0] r_slot_data [NUM_CH];
    logic [DATA_W-1:0] r_last_data [NUM_CH];

    logic [CH_W-1:0]   r_rr_ptr;
    logic [TS_W-1:0]   r_cycle;
    logic [DROP_W-1:0] r_drop;

    logic [CH_W:0]        w_scan;
    logic                 w_grant_found;
    logic [CH_W-1:0]      w_grant_idx;
    logic                 w_grant_valid;
    logic [NUM_CH-1:0]    w_granted;
    logic [NUM_CH-1:0]    w_qual;
    logic [NUM_CH-1:0]    w_drop_vec;
    logic [CH_W:0]        w_drop_inc;
    logic [DROP_W:0]      w_drop_sum;
    logic                 w_fifo_full;
    logic                 w_fifo_pop;
    logic                 w_can_push;
    logic [ENTRY_W-1:0]   w_push_data;

    assign w_fifo_pop = out_valid & out_ready;
    // A full FIFO still accepts a grant when the head leaves in the same cycle.
    assign w_can_push = ~w_fifo_full | w_fifo_pop;

    // Round-robin search. It starts at r_rr_ptr, which is the channel after
    // the last grant, and wraps at NUM_CH-1.
    always_comb begin
        w_scan        = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
            if (w_scan >= (CH_W+1)'(NUM_CH)) w_scan = w_scan - (CH_W+1)'(NUM_CH);
            if (!w_grant_found && r_pend[w_scan[CH_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan[CH_W-1:0];
            end
        end
    end

    assign w_grant_valid = w_grant_found & w_can_push;

    // Event qualification and drop detection. A slot being granted this cycle
    // counts as free, so a back-to-back event on that channel is not lost.
    always_comb begin
        w_qual     = '0;
        w_granted  = '0;
        w_drop_vec = '0;
        w_drop_inc = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_granted[c]  = w_grant_valid && (w_grant_idx == CH_W'(c));
            w_qual[c]     = enable & ch_mask[c] & ev_valid[c] &
                            (~change_only[c] | ~r_has_last[c] |
                             (ev_data[c*DATA_W +: DATA_W] != r_last_data[c]));
            w_drop_vec[c] = w_qual[c] & r_pend[c] & ~w_granted[c];
            w_drop_inc    = w_drop_inc + (CH_W+1)'(w_drop_vec[c]);
        end
    end

    assign w_drop_sum  = {1'b0, r_drop} + (DROP_W+1)'(w_drop_inc);
    assign w_push_data = {w_grant_idx, r_slot_ts[w_grant_idx],
                          r_slot_addr[w_grant_idx], r_slot_data[w_grant_idx]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_has_last <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_slot_ts[c]   <= '0;
                r_slot_addr[c] <= '0;
                r_slot_data[c] <= '0;
                r_last_data[c] <= '0;
            end
        end else if (clear) begin
            r_pend     <= '0;
            r_has_last <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_qual[c] && (!r_pend[c] || w_granted[c])) begin
                    r_pend[c]      <= 1'b1;
                    r_slot_ts[c]   <= r_cycle;
                    r_slot_addr[c] <= ev_addr[c*ADDR_W +: ADDR_W];
                    r_slot_data[c] <= ev_data[c*DATA_W +: DATA_W];
                    r_last_data[c] <= ev_data[c*DATA_W +: DATA_W];
                    r_has_last[c]  <= 1'b1;
                end else if (w_granted[c]) begin
                    r_pend[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_cycle  <= '0;
            r_drop   <= '0;
        end else if (clear) begin
            r_rr_ptr <= '0;
            r_cycle  <= '0;
            r_drop   <= '0;
        end else begin
            if (enable) r_cycle <= r_cycle + 1'b1;
            if (w_grant_valid) begin
                if (w_grant_idx == CH_W'(NUM_CH - 1)) r_rr_ptr <= '0;
                else                                  r_rr_ptr <= w_grant_idx + 1'b1;
            end
            if (w_drop_inc != '0) begin
                r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_push  (w_grant_valid),
        .i_data  (w_push_data),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_data  (out_entry),
        .o_full  (w_fifo_full),
        .o_count (fifo_count)
    );

    assign drop_count  = r_drop;
    assign cycle_count = r_cycle;

endmodule

// File: tb/tb_activity_trace_recorder.sv
module tb_activity_trace_recorder;
  import trace_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 6;
  localparam int TS_W    = 16;
  localparam int DEPTH   = 16;
  localparam int ENTRY_W = entry_w(NUM_CH, TS_W, ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     enable = 1'b0;
  logic                     clear = 1'b0;
  logic [NUM_CH-1:0]        ch_mask = '0;
  logic [NUM_CH-1:0]        change_only = '0;
  logic [NUM_CH-1:0]        ev_valid = '0;
  logic [NUM_CH*ADDR_W-1:0] ev_addr = '0;
  logic [NUM_CH*DATA_W-1:0] ev_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [ENTRY_W-1:0]       out_entry;
  logic [CNT_W-1:0]         fifo_count;
  logic [15:0]              drop_count;
  logic [TS_W-1:0]          cycle_count;

  activity_trace_recorder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clear       (clear),
    .ch_mask     (ch_mask),
    .change_only (change_only),
    .ev_valid    (ev_valid),
    .ev_addr     (ev_addr),
    .ev_data     (ev_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_entry   (out_entry),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count),
    .cycle_count (cycle_count)
  );

  // scoreboard
  logic [ENTRY_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference execution-cycle counter, which supplies the expected timestamps
  logic [TS_W-1:0] m_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      m_cyc <= '0;
    else if (clear)  m_cyc <= '0;
    else if (enable) m_cyc <= m_cyc + 1'b1;
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_entry", 64'(exp_q.size()), 64'd1);
      end else begin
        check("entry", 64'(out_entry), 64'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [ENTRY_W-1:0] mk(input int ch, input logic [TS_W-1:0] ts,
                                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    trace_entry_t e;
    e.ch_id = 2'(ch);
    e.ts    = ts;
    e.addr  = a;
    e.data  = d;
    return e;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ev_valid[ch] = 1'b1;
    ev_addr[ch*ADDR_W +: ADDR_W] = a;
    ev_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ENTRY_W-1:0] head;
    logic [DATA_W-1:0]  d;

    // reset state
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_cycle", 64'(cycle_count), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    ch_mask = 4'hF;
    out_ready = 1'b1;

    // single event, minimum latency, one beat
    do_clear();
    check("clr_cycle", 64'(cycle_count), 64'd0);
    repeat (10) tick();
    check("cycle10", 64'(cycle_count), 64'd10);
    set_ev(2, 6'd5, 16'h1234);
    exp_q.push_back(mk(2, m_cyc, 6'd5, 16'h1234));
    tick();
    ev_valid = '0;
    check("lat_t1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_t2_valid", 64'(out_valid), 64'd1);
    check("lat_t2_entry", 64'(out_entry), 64'(mk(2, 16'd10, 6'd5, 16'h1234)));
    tick();
    check("one_beat", 64'(out_valid), 64'd0);
    drain("drain_single");

    // all channels in one cycle: round-robin order ch0..ch3
    do_clear();
    repeat (2) tick();
    for (int c = 0; c < NUM_CH; c++) begin
      d = 16'(16'hA000 + $urandom_range(0, 16'h0FFF));
      set_ev(c, 6'(10 + c), d);
      exp_q.push_back(mk(c, m_cyc, 6'(10 + c), d));
    end
    tick();
    ev_valid = '0;
    drain("drain_all_ch");
    check("all_ch_drop", 64'(drop_count), 64'd0);

    // change-only suppression on ch1
    do_clear();
    change_only = 4'b0010;
    set_ev(1, 6'd3, 16'd7);
    exp_q.push_back(mk(1, m_cyc, 6'd3, 16'd7));
    tick();
    set_ev(1, 6'd3, 16'd7);
    tick();
    set_ev(1, 6'd3, 16'd9);
    exp_q.push_back(mk(1, m_cyc, 6'd3, 16'd9));
    tick();
    ev_valid = '0;
    drain("drain_change");
    check("change_drop", 64'(drop_count), 64'd0);
    change_only = '0;

    // back-pressure: DEPTH entries fill the FIFO, one waits in its slot,
    // and the last two are dropped
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_ev(0, 6'(i), 16'(16'h0100 + i));
      if (i <= DEPTH) exp_q.push_back(mk(0, m_cyc, 6'(i), 16'(16'h0100 + i)));
      tick();
    end
    ev_valid = '0;
    tick();
    check("full_count", 64'(fifo_count), 64'(DEPTH));
    check("full_drop", 64'(drop_count), 64'd2);
    head = exp_q[0];
    check("full_head", 64'(out_entry), 64'(head));
    repeat (3) tick();
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_head", 64'(out_entry), 64'(head));
    out_ready = 1'b1;
    drain("drain_full");

    // clear with 5 entries held and a ch3 event in the clear cycle
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ev(0, 6'd1, 16'(16'h0500 + i));
      exp_q.push_back(mk(0, m_cyc, 6'd1, 16'(16'h0500 + i)));
      tick();
    end
    ev_valid = '0;
    tick();
    check("pre_clr_count", 64'(fifo_count), 64'd5);
    check("pre_clr_drop", 64'(drop_count), 64'd2);
    clear = 1'b1;
    set_ev(3, 6'd7, 16'hCCCC);
    exp_q.delete();
    tick();
    clear = 1'b0;
    ev_valid = '0;
    check("clr_count", 64'(fifo_count), 64'd0);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_cyc", 64'(cycle_count), 64'd0);
    check("clr_drop", 64'(drop_count), 64'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    check("post_clr_count", 64'(fifo_count), 64'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ev(0, 6'd2, 16'(i));
      tick();
    end
    ev_valid = '0;
    tick();
    check("pre_rst_count", 64'(fifo_count), 64'd3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(fifo_count), 64'd0);
    check("arst_drop", 64'(drop_count), 64'd0);
    check("arst_cycle", 64'(cycle_count), 64'd0);
    set_ev(0, 6'd9, 16'hBEEF);
    exp_q.push_back(mk(0, 16'd0, 6'd9, 16'hBEEF));
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ev_valid = '0;
    drain("drain_after_rst");
    check("final_cycle", 64'(cycle_count), 64'(m_cyc));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
